// File: rtl/fp_decoder.sv
// fp_decoder: turns a small sign/exponent/significand float into a 12-bit
// two's-complement linear value, D = (S ? -1 : +1) * (F << E).
// The magnitude is shifted one bit per cycle, so the result takes E+1 cycles.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   S/E/F hold an encoded float
//   S, E, F    sign, exponent (0..7), significand (0..15)
//   in_ready   high only while idle; an input is taken when in_valid is also high
//   out_valid  D holds a finished result
//   out_ready  consumer takes D this cycle
//   D          decoded value, held after the handshake
//
// state  | meaning
// IDLE   | waiting for an input, in_ready=1
// SHIFT  | magnitude shifting left once per cycle, counter counts down
// FORMAT | apply the sign and load D
// DONE   | out_valid=1, waiting for out_ready

module fp_decoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        S,
   input  logic [2:0]  E,
   input  logic [3:0]  F,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] D
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FORMAT = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [10:0] mag;
   logic        sgn;

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         mag       <= 11'd0;
         sgn       <= 1'b0;
         out_valid <= 1'b0;
         D         <= 12'h000;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mag   <= {7'd0, F};
                  sgn   <= S;
                  cnt   <= E;
                  state <= (E == 3'd0) ? FORMAT : SHIFT;
               end
            end
            SHIFT: begin
               mag <= {mag[9:0], 1'b0};
               cnt <= cnt - 3'd1;
               // terminal count: this is the last shift
               if (cnt == 3'd1)
                  state <= FORMAT;
            end
            FORMAT: begin
               // negating a zero magnitude yields zero, so -0 never appears
               D         <= sgn ? (~{1'b0, mag} + 12'd1) : {1'b0, mag};
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_decoder.sv
module tb_fp_decoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        S;
   logic [2:0]  E;
   logic [3:0]  F;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] D;

   int n_checks = 0;
   int n_errors = 0;

   fp_decoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .S         (S),
      .E         (E),
      .F         (F),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference: signed product computed with plain integer arithmetic
   function automatic logic [11:0] ref_d(input logic s, input logic [2:0] e, input logic [3:0] f);
      int v;
      v = int'(f) * (1 << e);
      if (s) v = -v;
      return v[11:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns the edge count (accept edge = 0) at which out_valid was first seen
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_txn(input logic s, input logic [2:0] e, input logic [3:0] f, input int hold);
      int          lat;
      logic [11:0] exp_d;
      exp_d = ref_d(s, e, f);
      chk("idle_in_ready", in_ready, 1);
      S = s; E = e; F = f; in_valid = 1'b1;
      tick();
      // garbage while busy must be ignored
      in_valid = 1'($urandom_range(0, 1));
      S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
      chk("busy_in_ready", in_ready, 0);
      wait_valid(lat);
      chk("latency", lat, e + 1);
      chk("d_value", D, exp_d);
      repeat (hold) begin
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_d", D, exp_d);
         chk("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_valid", out_valid, 0);
      chk("hs_in_ready", in_ready, 1);
      chk("hs_d_keep", D, exp_d);
   endtask

   initial begin
      int lat;
      int seen;
      rst_n = 1'b0; in_valid = 1'b0; S = 1'b0; E = 3'd0; F = 4'd0; out_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      chk("rst_valid", out_valid, 0);
      chk("rst_d", D, 12'h000);
      chk("rst_in_ready", in_ready, 1);

      // out_ready with nothing pending has no effect
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      chk("idle_ready_noeffect_valid", out_valid, 0);
      chk("idle_ready_noeffect_in_ready", in_ready, 1);

      // directed scenarios
      do_txn(1'b0, 3'd0, 4'b0101, 0);
      do_txn(1'b0, 3'd7, 4'b1111, 1);
      do_txn(1'b1, 3'd3, 4'b1010, 2);
      do_txn(1'b1, 3'd5, 4'b0000, 0);

      // stalled output with a new input waiting
      S = 1'b0; E = 3'd2; F = 4'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid(lat);
      chk("stall_first_d", D, ref_d(1'b0, 3'd2, 4'd3));
      S = 1'b0; E = 3'd1; F = 4'b0001; in_valid = 1'b1;
      repeat (5) begin
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_d", D, 12'h00C);
         chk("stall_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("stall_hs_valid", out_valid, 0);
      chk("stall_hs_in_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("stall_accept", in_ready, 0);
      wait_valid(lat);
      chk("stall_second_latency", lat, 2);
      chk("stall_second_d", D, 12'h002);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // randomized traffic
      for (int i = 0; i < 40; i++)
         do_txn(1'($urandom), 3'($urandom), 4'($urandom), $urandom_range(0, 3));

      // reset in the middle of SHIFT abandons the operation
      S = 1'b0; E = 3'd6; F = 4'b1000; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      in_valid = 1'b1; S = 1'b1; E = 3'd2; F = 4'd9;
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_d", D, 12'h000);
      chk("midrst_in_ready", in_ready, 1);
      seen = 0;
      repeat (20) begin
         tick();
         if (out_valid) seen++;
      end
      chk("midrst_no_result", seen, 0);
      chk("midrst_idle", in_ready, 1);

      do_txn(1'b1, 3'd1, 4'd7, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
